alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter that shares the single registered integer ALU between two requesters, for example the main execute path and a secondary address/branch-compare path. It accepts operation requests over valid/ready handshakes and arbitrates round-robin, or with fixed priority when configured. It drives the ALU's one-hot operation select and operands, tracks the one-cycle ALU latency, and returns each result to its owner through a one-entry response buffer per port.

## Interface

Parameters:
- PRIO_FIXED, 0: arbitration mode. 0 = round-robin; 1 = port 0 always wins a conflict.

Ports:
- CLK in 1: clock. Everything samples on the rising edge.
- RSTN in 1: reset. One clock; asynchronous, active-low.
- REQ0_VALID in 1: port 0 has a request.
- REQ0_READY out 1: port 0 request accepted this cycle if REQ0_VALID.
- REQ0_OP in 4: operation code. 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
- REQ0_RS1 in 32, REQ0_RS2 in 32: operands.
- RSP0_VALID out 1: port 0 result pending.
- RSP0_READY in 1: port 0 consumer takes the result.
- RSP0_RESULT out 32: port 0 result.
- REQ1_* / RSP1_*: identical set of signals for port 1.
- ALU_SEL out 10: one-hot op select to the ALU. Bit 0 = add … bit 9 = and, in opcode order.
- ALU_RS1 out 32, ALU_RS2 out 32: ALU operands.
- ALU_RESULT in 32: registered ALU output. It is valid one cycle after ALU_SEL/operands are presented.

## Operation

State:
- Round-robin pointer `last` (1 bit).
- Issue-tracking register `ifl_v`, `ifl_id`.
- Per-port response buffer `rsp_v[x]`, `rsp_d[x]`.

Eligibility: port x is eligible when `rsp_v[x]==0 || RSPx_READY`, and not `(ifl_v && ifl_id==x)`. This gives at most one outstanding operation per port.

Grant:
- Port x wins when it is eligible and either the other port is not (valid and eligible), or priority favours x.
- Priority favours port 0 if PRIO_FIXED=1.
- Otherwise priority favours the port not equal to `last`.
- REQx_READY = eligible_x && not lost to the other port. REQx_READY never depends on REQx_VALID (no combinational loop).

Issue, on cycle C with REQx_VALID && REQx_READY:
- ALU_SEL is the one-hot decode of REQx_OP, combinational in C. ALU_RS1/ALU_RS2 = REQx_RS1/RS2.
- Opcode 10–15 drives ALU_SEL=0. The ALU returns 0 and that is delivered as the result; this is not an error.
- End of C: `ifl_v<=1`, `ifl_id<=x`, and `last<=x` (round-robin mode only).
- With no issue in a cycle: `ifl_v<=0`, ALU_SEL=0, ALU operands=0.

Capture, cycle C+1 with `ifl_v`:
- End of C+1: `rsp_d[ifl_id]<=ALU_RESULT`, `rsp_v[ifl_id]<=1`.

Response:
- RSPx_VALID = `rsp_v[x]`, RSPx_RESULT = `rsp_d[x]`.
- When RSPx_VALID && RSPx_READY and no capture for x that cycle, `rsp_v[x]<=0`.
- If a pop and a capture for x coincide, the capture wins and `rsp_v[x]` stays 1 with the new data.
- `rsp_d[x]` holds stable while RSPx_VALID && !RSPx_READY.

## Timing

- Reset (asynchronous assert, synchronous release):
  - `last=1`, so port 0 wins the first conflict.
  - `ifl_v=0`, `rsp_v=0`, `rsp_d=0`.
  - Outputs: RSP*_VALID=0, RSP*_RESULT=0, ALU_SEL=0, ALU_RS*=0.
  - REQ*_READY=1 as soon as the state is clear. Port 1 READY is 0 whenever REQ0_VALID=1 (first conflict goes to port 0).
- Latency: handshake in C → RSPx_VALID in C+2, when the buffer was free.
- Throughput:
  - ALU: one issue per cycle overall.
  - Single port with an always-ready consumer: one issue every 2 cycles. The in-flight check blocks C+1; the pop in C+2 lets issue proceed in C+2.
- Both ports busy, round-robin: grants alternate 0,1,0,1 with one issue every cycle.
- A stalled consumer (RSPx_READY=0 with `rsp_v[x]=1`) blocks only port x. The other port proceeds.
- Reset mid-operation: the in-flight op and buffered results are discarded. The ALU register value is ignored because `ifl_v=0`.

## Test plan

- Reset, then port 0 add 5+7 in cycle 1 → ALU_SEL=10'b0000000001 in cycle 1; RSP0_VALID, RSP0_RESULT=12 in cycle 3.
- Both ports valid continuously (port 0: sub 10-3; port 1: sra 0x80000000,4) with RSP_READY=1 → grants 0,1,0,1,… every cycle; results 7 and 0xF8000000 alternate.
- PRIO_FIXED=1, both ports valid for 6 cycles → port 1 READY stays 0 except in cycles where port 0 is ineligible (every other cycle); no ALU idle cycles.
- Port 1 RSP1_READY=0 after one result (slt -1,1 → 1) → REQ1_READY=0 and the result holds at 1; port 0 traffic keeps flowing; raising RSP1_READY releases port 1.
- Opcode 12 from port 0 → ALU_SEL=0, RSP0_RESULT=0 two cycles later.
- RSTN pulled low the cycle after an issue → RSP*_VALID stays 0 after release; the next request completes normally with 2-cycle latency.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one registered integer ALU between two requesters.
// Each port has a valid/ready request channel and a one-entry response
// buffer. A port may have at most one operation outstanding. Conflicts are
// resolved round-robin, or with port 0 always winning when PRIO_FIXED != 0.
module alu_share_arb #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic        CLK,
  input  logic        RSTN,
  // port 0 request / response
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [3:0]  REQ0_OP,
  input  logic [31:0] REQ0_RS1,
  input  logic [31:0] REQ0_RS2,
  output logic        RSP0_VALID,
  input  logic        RSP0_READY,
  output logic [31:0] RSP0_RESULT,
  // port 1 request / response
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [3:0]  REQ1_OP,
  input  logic [31:0] REQ1_RS1,
  input  logic [31:0] REQ1_RS2,
  output logic        RSP1_VALID,
  input  logic        RSP1_READY,
  output logic [31:0] RSP1_RESULT,
  // shared ALU
  output logic [9:0]  ALU_SEL,
  output logic [31:0] ALU_RS1,
  output logic [31:0] ALU_RS2,
  input  logic [31:0] ALU_RESULT
);

  // last_q == 1 means port 0 is favoured in the next conflict
  logic             last_q, last_d;
  logic             ifl_v_q, ifl_v_d;
  logic             ifl_id_q, ifl_id_d;
  logic [1:0]       rsp_v_q, rsp_v_d;
  logic [1:0][31:0] rsp_data_q, rsp_data_d;

  logic       elig0, elig1;
  logic       prio0;
  logic       issue0, issue1;
  logic [1:0] rsp_rdy;

  // Opcodes 0..9 map to one select bit each; anything else selects nothing,
  // so the ALU returns 0 and that zero is delivered as a normal result.
  function automatic logic [9:0] op_onehot(input logic [3:0] op);
    logic [9:0] sel;
    sel = '0;
    if (op <= 4'd9) sel = 10'd1 << op;
    return sel;
  endfunction

  assign rsp_rdy = {RSP1_READY, RSP0_READY};

  // Eligibility, priority and grant; READY deliberately ignores own VALID
  always_comb begin
    elig0 = (!rsp_v_q[0] || RSP0_READY) && !(ifl_v_q && (ifl_id_q == 1'b0));
    elig1 = (!rsp_v_q[1] || RSP1_READY) && !(ifl_v_q && (ifl_id_q == 1'b1));
    prio0 = (PRIO_FIXED != 0) || last_q;
    REQ0_READY = elig0 && !(REQ1_VALID && elig1 && !prio0);
    REQ1_READY = elig1 && !(REQ0_VALID && elig0 && prio0);
    issue0 = REQ0_VALID && REQ0_READY;
    issue1 = REQ1_VALID && REQ1_READY;
  end

  // Drive the ALU from the issuing port and record what is in flight
  always_comb begin
    ALU_SEL  = '0;
    ALU_RS1  = '0;
    ALU_RS2  = '0;
    ifl_v_d  = 1'b0;
    ifl_id_d = ifl_id_q;
    last_d   = last_q;
    if (issue0) begin
      ALU_SEL  = op_onehot(REQ0_OP);
      ALU_RS1  = REQ0_RS1;
      ALU_RS2  = REQ0_RS2;
      ifl_v_d  = 1'b1;
      ifl_id_d = 1'b0;
      if (PRIO_FIXED == 0) last_d = 1'b0;
    end else if (issue1) begin
      ALU_SEL  = op_onehot(REQ1_OP);
      ALU_RS1  = REQ1_RS1;
      ALU_RS2  = REQ1_RS2;
      ifl_v_d  = 1'b1;
      ifl_id_d = 1'b1;
      if (PRIO_FIXED == 0) last_d = 1'b1;
    end
  end

  // Response buffers: capture of the in-flight result wins over a pop
  always_comb begin
    rsp_v_d    = rsp_v_q;
    rsp_data_d = rsp_data_q;
    for (int x = 0; x < 2; x++) begin
      if (ifl_v_q && (ifl_id_q == 1'(x))) begin
        rsp_v_d[x]    = 1'b1;
        rsp_data_d[x] = ALU_RESULT;
      end else if (rsp_v_q[x] && rsp_rdy[x]) begin
        rsp_v_d[x] = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight op and buffered results
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_q     <= 1'b1;
      ifl_v_q    <= 1'b0;
      ifl_id_q   <= 1'b0;
      rsp_v_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      last_q     <= last_d;
      ifl_v_q    <= ifl_v_d;
      ifl_id_q   <= ifl_id_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign RSP0_VALID  = rsp_v_q[0];
  assign RSP1_VALID  = rsp_v_q[1];
  assign RSP0_RESULT = rsp_data_q[0];
  assign RSP1_RESULT = rsp_data_q[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb. Two instances share the stimulus:
// u_dut_rr (round-robin) and u_dut_fx (fixed priority). Each has its own
// registered ALU model closing the loop on ALU_SEL/operands.
module tb_alu_share_arb;

  logic        CLK;
  logic        RSTN;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic        rsp0_ready, rsp1_ready;

  logic        r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid;
  logic [31:0] r_rsp0_result, r_rsp1_result, r_alu_rs1, r_alu_rs2, r_alu_res;
  logic [9:0]  r_alu_sel;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp0_result, f_rsp1_result, f_alu_rs1, f_alu_rs2, f_alu_res;
  logic [9:0]  f_alu_sel;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arb #(.PRIO_FIXED(0)) u_dut_rr (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0_VALID(req0_valid), .REQ0_READY(r_req0_ready), .REQ0_OP(req0_op),
    .REQ0_RS1(req0_rs1), .REQ0_RS2(req0_rs2),
    .RSP0_VALID(r_rsp0_valid), .RSP0_READY(rsp0_ready), .RSP0_RESULT(r_rsp0_result),
    .REQ1_VALID(req1_valid), .REQ1_READY(r_req1_ready), .REQ1_OP(req1_op),
    .REQ1_RS1(req1_rs1), .REQ1_RS2(req1_rs2),
    .RSP1_VALID(r_rsp1_valid), .RSP1_READY(rsp1_ready), .RSP1_RESULT(r_rsp1_result),
    .ALU_SEL(r_alu_sel), .ALU_RS1(r_alu_rs1), .ALU_RS2(r_alu_rs2), .ALU_RESULT(r_alu_res)
  );

  alu_share_arb #(.PRIO_FIXED(1)) u_dut_fx (
    .CLK(CLK), .RSTN(RSTN),
    .REQ0_VALID(req0_valid), .REQ0_READY(f_req0_ready), .REQ0_OP(req0_op),
    .REQ0_RS1(req0_rs1), .REQ0_RS2(req0_rs2),
    .RSP0_VALID(f_rsp0_valid), .RSP0_READY(rsp0_ready), .RSP0_RESULT(f_rsp0_result),
    .REQ1_VALID(req1_valid), .REQ1_READY(f_req1_ready), .REQ1_OP(req1_op),
    .REQ1_RS1(req1_rs1), .REQ1_RS2(req1_rs2),
    .RSP1_VALID(f_rsp1_valid), .RSP1_READY(rsp1_ready), .RSP1_RESULT(f_rsp1_result),
    .ALU_SEL(f_alu_sel), .ALU_RS1(f_alu_rs1), .ALU_RS2(f_alu_rs2), .ALU_RESULT(f_alu_res)
  );

  // Reference ALU: one-hot select, registered output
  function automatic logic [31:0] alu_f(input logic [9:0] sel, input logic [31:0] a,
                                       input logic [31:0] b);
    case (sel)
      10'h001: return a + b;
      10'h002: return a - b;
      10'h004: return a << b[4:0];
      10'h008: return {31'd0, $signed(a) < $signed(b)};
      10'h010: return {31'd0, a < b};
      10'h020: return a ^ b;
      10'h040: return a >> b[4:0];
      10'h080: return $unsigned($signed(a) >>> b[4:0]);
      10'h100: return a | b;
      10'h200: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    r_alu_res <= alu_f(r_alu_sel, r_alu_rs1, r_alu_rs2);
    f_alu_res <= alu_f(f_alu_sel, f_alu_rs1, f_alu_rs2);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b;
  endtask

  task automatic drv1(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b;
  endtask

  initial begin
    logic g;
    RSTN = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    drv1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;

    // reset state
    check("rst_rsp0_v",  32'(r_rsp0_valid), 32'd0);
    check("rst_rsp1_v",  32'(r_rsp1_valid), 32'd0);
    check("rst_rsp0_d",  r_rsp0_result, 32'd0);
    check("rst_rsp1_d",  r_rsp1_result, 32'd0);
    check("rst_sel",     32'(r_alu_sel), 32'd0);
    check("rst_rs1",     r_alu_rs1, 32'd0);
    check("rst_rdy0",    32'(r_req0_ready), 32'd1);
    check("rst_rdy1",    32'(r_req1_ready), 32'd1);
    req0_valid = 1'b1;
    #1;
    check("rst_rdy1_conf", 32'(r_req1_ready), 32'd0);
    req0_valid = 1'b0;
    RSTN = 1'b1;

    // add 5+7 from port 0, result two cycles later
    drv0(1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    check("add_sel",  32'(r_alu_sel), 32'h001);
    check("add_rs1",  r_alu_rs1, 32'd5);
    check("add_rs2",  r_alu_rs2, 32'd7);
    check("add_rdy0", 32'(r_req0_ready), 32'd1);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("add_c1_v",   32'(r_rsp0_valid), 32'd0);
    check("add_c1_sel", 32'(r_alu_sel), 32'd0);
    check("add_c1_rdy", 32'(r_req0_ready), 32'd0);
    tick();
    #1;
    check("add_c2_v", 32'(r_rsp0_valid), 32'd1);
    check("add_c2_d", r_rsp0_result, 32'd12);
    tick();
    #1;
    check("add_pop_v", 32'(r_rsp0_valid), 32'd0);

    // both ports busy, round-robin; port 0 issued last so port 1 goes first
    drv0(1'b1, 4'd1, 32'd10, 32'd3);
    drv1(1'b1, 4'd7, 32'h8000_0000, 32'd4);
    for (int k = 0; k < 6; k++) begin
      #1;
      g = (k % 2 == 0);
      check("rr_sel",  32'(r_alu_sel), g ? 32'h080 : 32'h002);
      check("rr_rdy0", 32'(r_req0_ready), 32'(!g));
      check("rr_rdy1", 32'(r_req1_ready), 32'(g));
      if (k >= 2) begin
        check("rr_rsp_v", 32'(g ? r_rsp1_valid : r_rsp0_valid), 32'd1);
        check("rr_rsp_d", g ? r_rsp1_result : r_rsp0_result, g ? 32'hF800_0000 : 32'd7);
      end
      tick();
    end
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    drv1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();
    check("rr_end_d0", r_rsp0_result, 32'd7);
    check("rr_end_d1", r_rsp1_result, 32'hF800_0000);

    // fixed priority: port 1 only gets in when port 0 is in flight
    RSTN = 1'b0;
    #1;
    RSTN = 1'b1;
    tick();
    drv0(1'b1, 4'd0, 32'd1, 32'd1);
    drv1(1'b1, 4'd8, 32'h0000_00F0, 32'h0000_000F);
    for (int k = 0; k < 6; k++) begin
      #1;
      g = (k % 2 == 1);
      check("fx_rdy1", 32'(f_req1_ready), 32'(g));
      check("fx_sel",  32'(f_alu_sel), g ? 32'h100 : 32'h001);
      tick();
    end
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    drv1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();
    check("fx_d0", f_rsp0_result, 32'd2);
    check("fx_d1", f_rsp1_result, 32'h0000_00FF);
    // port 0 alone, then a conflict: round-robin favours 1, fixed favours 0
    drv0(1'b1, 4'd0, 32'd1, 32'd1);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();
    drv0(1'b1, 4'd0, 32'd1, 32'd1);
    drv1(1'b1, 4'd8, 32'h0000_00F0, 32'h0000_000F);
    #1;
    check("mode_rr_rdy0", 32'(r_req0_ready), 32'd0);
    check("mode_rr_rdy1", 32'(r_req1_ready), 32'd1);
    check("mode_fx_rdy0", 32'(f_req0_ready), 32'd1);
    check("mode_fx_rdy1", 32'(f_req1_ready), 32'd0);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    drv1(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) tick();

    // port 1 consumer stalls; port 0 keeps flowing
    rsp1_ready = 1'b0;
    drv1(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1);
    #1;
    check("st_a_rdy1", 32'(r_req1_ready), 32'd1);
    tick();
    drv1(1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1);
    drv0(1'b1, 4'd0, 32'd2, 32'd3);
    #1;
    check("st_b_rdy1", 32'(r_req1_ready), 32'd0);
    check("st_b_rdy0", 32'(r_req0_ready), 32'd1);
    tick();
    #1;
    check("st_c_v1",   32'(r_rsp1_valid), 32'd1);
    check("st_c_d1",   r_rsp1_result, 32'd1);
    check("st_c_rdy1", 32'(r_req1_ready), 32'd0);
    check("st_c_rdy0", 32'(r_req0_ready), 32'd0);
    tick();
    #1;
    check("st_d_v0",   32'(r_rsp0_valid), 32'd1);
    check("st_d_d0",   r_rsp0_result, 32'd5);
    check("st_d_rdy1", 32'(r_req1_ready), 32'd0);
    check("st_d_rdy0", 32'(r_req0_ready), 32'd1);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("st_e_d1",   r_rsp1_result, 32'd1);
    check("st_e_rdy1", 32'(r_req1_ready), 32'd0);
    tick();
    rsp1_ready = 1'b1;
    #1;
    check("st_f_rdy1", 32'(r_req1_ready), 32'd1);
    tick();
    drv1(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("st_g_v1", 32'(r_rsp1_valid), 32'd0);
    tick();
    #1;
    check("st_h_v1", 32'(r_rsp1_valid), 32'd1);
    check("st_h_d1", r_rsp1_result, 32'd0);
    tick();

    // undefined opcode delivers zero
    drv0(1'b1, 4'd12, 32'd9, 32'd9);
    #1;
    check("op12_sel",  32'(r_alu_sel), 32'd0);
    check("op12_rdy0", 32'(r_req0_ready), 32'd1);
    check("op12_rs1",  r_alu_rs1, 32'd9);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    #1;
    check("op12_v", 32'(r_rsp0_valid), 32'd1);
    check("op12_d", r_rsp0_result, 32'd0);
    tick();

    // reset the cycle after an issue discards the op
    drv0(1'b1, 4'd0, 32'd5, 32'd7);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    RSTN = 1'b0;
    #1;
    check("mr_async_v", 32'(r_rsp0_valid), 32'd0);
    #2;
    RSTN = 1'b1;
    tick();
    #1;
    check("mr_v_a", 32'(r_rsp0_valid), 32'd0);
    check("mr_d_a", r_rsp0_result, 32'd0);
    tick();
    #1;
    check("mr_v_b", 32'(r_rsp0_valid), 32'd0);
    drv0(1'b1, 4'd0, 32'd3, 32'd4);
    tick();
    drv0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    check("mr_next_c1", 32'(r_rsp0_valid), 32'd0);
    tick();
    #1;
    check("mr_next_v", 32'(r_rsp0_valid), 32'd1);
    check("mr_next_d", r_rsp0_result, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
